// File: rtl/ss_hotkey_rdr.sv
// Controller-port sniffer for up to two pads with a debounced save-state hotkey matcher.
// Bus signals are sampled on the fast clock; m2 is never used as a clock.
module ss_hotkey_rdr #(
  parameter int PORTS = 2,
  parameter int BITS  = 8,
  parameter int KEYS  = 3,
  parameter int HOLD  = 4
) (
  input  logic                        clk,
  input  logic                        sys_rst_n,
  input  logic                        m2,
  input  logic [15:0]                 cpu_addr,
  input  logic [7:0]                  cpu_dat,
  input  logic                        cpu_rw,
  input  logic                        map_rst,
  input  logic                        ss_on,
  input  logic                        ext_btn,
  input  logic [KEYS*BITS-1:0]        key_tbl,
  input  logic                        ss_ack,
  output logic [PORTS*BITS-1:0]       joy,
  output logic [PORTS-1:0]            joy_upd,
  output logic                        ss_req,
  output logic [$clog2(KEYS+1)-1:0]   ss_key,
  output logic [BITS-1:0]             ss_src
);

  localparam int          KW       = $clog2(KEYS+1);
  localparam logic [15:0] JOY_BASE = 16'h4016;
  localparam logic [7:0]  HOLD_C   = 8'(HOLD);

  typedef enum logic [1:0] {IDLE, HOLDING, FIRED, WAIT_REL} state_e;

  // Bus pipeline: index 1 is the decode stage, m2_q[2] only serves edge detection.
  logic [2:0]  m2_q,   m2_d;
  logic [15:0] addr_q [2];
  logic [15:0] addr_d [2];
  logic [7:0]  dat_q  [2];
  logic [7:0]  dat_d  [2];
  logic [1:0]  rw_q,   rw_d;

  logic                load_q, load_d;
  logic [BITS:0]       buff_q [PORTS];
  logic [BITS:0]       buff_d [PORTS];
  logic [BITS-1:0]     joy_q  [PORTS];
  logic [BITS-1:0]     joy_d  [PORTS];
  logic [PORTS-1:0]    done_q, done_d;
  logic [PORTS-1:0]    upd_q,  upd_d;

  state_e              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [KW-1:0]       cur_q, cur_d;
  logic                ext_q, ext_d;
  logic                ss_req_q, ss_req_d;
  logic [KW-1:0]       ss_key_q, ss_key_d;
  logic [BITS-1:0]     ss_src_q, ss_src_d;

  logic                cyc;
  logic                dat_unused;
  logic                match_vld;
  logic [KW-1:0]       match_idx;
  logic                fire_rep, fire_ext;
  logic                hk_clr, ext_rise, rep_ev;
  logic [7:0]          cnt_inc;

  assign cyc        = m2_q[2] & ~m2_q[1];
  assign dat_unused = ^dat_q[1][7:2];
  assign hk_clr     = map_rst | ~ss_on;
  assign ext_rise   = ext_btn & ~ext_q;
  assign rep_ev     = upd_q[0];
  assign cnt_inc    = (cnt_q >= HOLD_C) ? HOLD_C : cnt_q + 8'd1;

  always_comb begin
    m2_d      = {m2_q[1:0], m2};
    addr_d[0] = cpu_addr;
    addr_d[1] = addr_q[0];
    dat_d[0]  = cpu_dat;
    dat_d[1]  = dat_q[0];
    rw_d      = {rw_q[0], cpu_rw};
    ext_d     = ext_btn;
  end

  always_comb begin
    load_d = load_q;
    if (cyc && !rw_q[1] && addr_q[1] == JOY_BASE)
      load_d = dat_q[1][0];
    for (int unsigned p = 0; p < PORTS; p++) begin
      buff_d[p] = buff_q[p];
      joy_d[p]  = joy_q[p];
      done_d[p] = done_q[p];
      upd_d[p]  = 1'b0;
      // The sentinel reaching bit BITS marks a complete report.
      if (load_q) begin
        buff_d[p] = (BITS+1)'(1);
        done_d[p] = 1'b0;
      end else if (buff_q[p][BITS] && !done_q[p]) begin
        joy_d[p]  = buff_q[p][BITS-1:0];
        done_d[p] = 1'b1;
        upd_d[p]  = 1'b1;
      end else if (cyc && rw_q[1] && addr_q[1] == JOY_BASE + 16'(p) && !done_q[p]) begin
        buff_d[p] = {buff_q[p][BITS-1:0], dat_q[1][0] | dat_q[1][1]};
      end
    end
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      m2_q   <= '0;
      addr_q <= '{default: '0};
      dat_q  <= '{default: '0};
      rw_q   <= '0;
      load_q <= 1'b0;
      buff_q <= '{default: '0};
      joy_q  <= '{default: '0};
      done_q <= '0;
      upd_q  <= '0;
    end else begin
      m2_q   <= m2_d;
      addr_q <= addr_d;
      dat_q  <= dat_d;
      rw_q   <= rw_d;
      load_q <= load_d;
      buff_q <= buff_d;
      joy_q  <= joy_d;
      done_q <= done_d;
      upd_q  <= upd_d;
    end
  end

  always_comb begin
    match_vld = 1'b0;
    match_idx = '0;
    for (int unsigned k = 0; k < KEYS; k++) begin
      if (!match_vld && key_tbl[k*BITS +: BITS] != '0 && key_tbl[k*BITS +: BITS] == joy_q[0]) begin
        match_vld = 1'b1;
        match_idx = KW'(k);
      end
    end
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      cur_q    <= '0;
      ext_q    <= 1'b0;
      ss_req_q <= 1'b0;
      ss_key_q <= '0;
      ss_src_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cur_q    <= cur_d;
      ext_q    <= ext_d;
      ss_req_q <= ss_req_d;
      ss_key_q <= ss_key_d;
      ss_src_q <= ss_src_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cur_d    = cur_q;
    fire_rep = 1'b0;
    fire_ext = 1'b0;
    if (hk_clr) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE, HOLDING: begin
          if (ext_rise) begin
            fire_ext = 1'b1;
          end else if (rep_ev) begin
            if (!match_vld) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              if (state_q == HOLDING && match_idx == cur_q) begin
                cnt_d = cnt_inc;
              end else begin
                cnt_d = 8'd1;
                cur_d = match_idx;
              end
              state_d  = HOLDING;
              fire_rep = (cnt_d >= HOLD_C);
            end
          end
          if (fire_ext || fire_rep)
            state_d = FIRED;
        end
        FIRED: begin
          if (ss_ack)
            state_d = WAIT_REL;
        end
        WAIT_REL: begin
          if (rep_ev && !match_vld) begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    ss_req_d = ss_req_q;
    ss_key_d = ss_key_q;
    ss_src_d = ss_src_q;
    if (hk_clr) begin
      ss_req_d = 1'b0;
    end else if (state_q == FIRED && ss_ack) begin
      ss_req_d = 1'b0;
    end else if (fire_ext) begin
      ss_req_d = 1'b1;
      ss_key_d = KW'(KEYS);
      ss_src_d = joy_q[0];
    end else if (fire_rep) begin
      ss_req_d = 1'b1;
      ss_key_d = cur_d;
      ss_src_d = joy_q[0];
    end
  end

  always_comb begin
    joy = '0;
    for (int unsigned p = 0; p < PORTS; p++)
      joy[p*BITS +: BITS] = joy_q[p];
  end

  assign joy_upd = upd_q;
  assign ss_req  = ss_req_q;
  assign ss_key  = ss_key_q;
  assign ss_src  = ss_src_q;

endmodule

// File: doc/ss_hotkey_rdr.md
Name: ss_hotkey_rdr

Overview:
- Parametrised successor to the single-port joypad reader and save-state hotkey detector.
- Sniffs CPU controller-port traffic ($4016/$4017) for up to PORTS controllers with configurable report length, e.g. 8-bit standard or 24-bit Four Score.
- Matches port 0 against KEYS programmable hotkey slots, with hold-time debounce and re-arm.
- Issues a level save-state request with a req/ack handshake.
- Runs on the fast system clock. m2 is sampled rather than used as a clock.

Parameters:
PORTS, 2, number of sniffed controller ports (1..2); port p decodes at $4016+p.
BITS, 8, report bits per port (1..32).
KEYS, 3, number of hotkey slots.
HOLD, 4, consecutive matching port-0 reports required to fire (1..255).

Ports:
clk  in  1  system clock
sys_rst_n  in  1  asynchronous active-low reset
m2  in  1  CPU phase-2, asynchronous to clk
cpu_addr  in  16  CPU address
cpu_dat  in  8  CPU data bus
cpu_rw  in  1  1 = read
map_rst  in  1  mapper reset; synchronous clear of hotkey logic
ss_on  in  1  save-state feature enable
ext_btn  in  1  cartridge button request, level
key_tbl  in  KEYS*BITS  hotkey patterns; slot k = [k*BITS +: BITS]; all-zero = disabled
ss_ack  in  1  menu acknowledge, one clk pulse
joy  out  PORTS*BITS  last complete report per port
joy_upd  out  PORTS  one-clk pulse per port when joy updates
ss_req  out  1  save-state request, level
ss_key  out  clog2(KEYS+1)  winning slot; KEYS = ext_btn
ss_src  out  BITS  port-0 report captured at fire

Behaviour:
- Reset (sys_rst_n low, async): all registers 0, including outputs, shift regs, counters, load, done flags and the m2 pipeline.
- Bus sampling:
  - m2, cpu_addr, cpu_dat and cpu_rw pass together through a 2-flop pipeline.
  - cyc = one-clk strobe when the pipelined m2 goes 1->0.
  - All bus decode below acts only on cyc, using the pipelined bus values.
- Strobe latch: cyc & write & addr==$4016 -> load <= dat[0].
- Shift register per port, BITS+1 wide (buff_p):
  - load=1: buff_p <= 1 (sentinel); done_p <= 0.
  - Otherwise, if buff_p[BITS]=1 and done_p=0: joy_p <= buff_p[BITS-1:0], done_p <= 1, joy_upd[p] pulses the next clk.
  - Otherwise, if cyc & read & addr==$4016+p & !done_p: buff_p <= {buff_p[BITS-1:0], dat[0]|dat[1]}.
  - Reads beyond BITS are ignored until the next strobe.
  - A strobe write during a partial shift aborts that shift; joy_p keeps its old value.
- Hotkey FSM, states IDLE, HOLDING, FIRED, WAIT_REL:
  - Evaluated on joy_upd[0] only.
  - match = lowest k with key_k != 0 and key_k == new joy_0.
  - IDLE: match -> HOLDING with cnt=1 and cur=k. If HOLD=1, fire immediately.
  - HOLDING:
    - same k -> cnt++; when cnt reaches HOLD, fire.
    - different match -> restart with cnt=1, cur=new k.
    - no match -> IDLE.
  - Fire: ss_req <= 1, ss_key <= cur, ss_src <= joy_0, state FIRED.
  - FIRED: ignore matches and ext_btn. ss_ack -> ss_req <= 0, state WAIT_REL.
  - WAIT_REL: the first port-0 report with no match -> IDLE. A held key never re-fires.
- ext_btn:
  - Rising edge in IDLE or HOLDING fires immediately with ss_key=KEYS and ss_src=joy_0.
  - Priority: ext_btn wins over a report-driven fire in the same clk.
- ss_ack outside FIRED is ignored.
- ss_ack and a new fire in the same clk: ack wins, then WAIT_REL.
- map_rst=1 or ss_on=0 (synchronous, every clk): FSM -> IDLE, cnt=0, ss_req=0. The joy capture path is unaffected.
- cnt is 8 bits and saturates at HOLD.

Test Plan:
- Standard read, PORTS=2, BITS=8: write $4016=1 then 0; 8 reads of $4016 with dat[0]=1,0,1,0,0,0,0,1 -> joy_0=8'hA1, one joy_upd[0] pulse. A 9th read leaves joy_0 unchanged.
- Port isolation: 8 reads of $4017 with pattern 8'h3C, no $4016 reads -> joy_1=8'h3C, joy_0 unchanged, only joy_upd[1] pulses.
- Hold debounce, HOLD=4, key_tbl slot1=8'h30:
  - 3 frames of 8'h30 -> ss_req stays 0.
  - 4th frame -> ss_req=1, ss_key=1, ss_src=8'h30.
  - ss_ack -> ss_req=0.
  - 2 more frames of 8'h30 -> no refire.
  - Frame 8'h00, then 4 frames of 8'h30 -> refire.
- Slot priority and restart: slots 0 and 2 both =8'h11 -> ss_key=0. Sequence 8'h11,8'h11,8'h22(slot1),8'h11 gives cnt=1 on the last frame, not 3.
- Abort: strobe write after 5 reads -> joy_0 keeps its previous value. Then a full 8-read sequence -> normal update. With BITS=24, 24 reads -> joy_0 holds the 24-bit value.
- ext_btn and reset:
  - ext_btn rising in HOLDING -> ss_key=3 (KEYS), ss_req=1.
  - map_rst pulse -> ss_req=0, state IDLE.
  - sys_rst_n low mid-shift -> all outputs 0 immediately, with no clk edge.
